cmp_scheduler: RTL and testbench

- Sequences the shared bus comparator across NCH monitored channels.
- Each single-cycle `tick` strobe from the clock divider (the periodic `clkPls` pulse) starts one comparison round.
- A round walks enabled channels in ascending order, handing each to the comparator with a start/done handshake.
- Collects per-channel sticky mismatch flags and timeout/overrun status for the status logic.

---
 rtl/cmp_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_cmp_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_scheduler.sv
// ---------------------------------------------------------------------------
// cmp_scheduler
// Sequences one shared bus comparator across NCH monitored channels. Each
// tick starts a round that visits the enabled channels in ascending order,
// runs a start/done handshake with the comparator for each one, and gathers
// sticky mismatch, timeout and overrun status.
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   tick          : one-cycle round-start strobe
//   ch_en         : channel enable mask, captured only at round start
//   err_clr       : clears err_vec, timeout_err, overrun (and stats)
//   cmp_start     : one-cycle start pulse to the comparator
//   cmp_sel       : channel under comparison, held until done/timeout
//   cmp_done      : comparator finished pulse
//   cmp_mismatch  : comparator result, qualified by cmp_done
//   busy          : round in progress
//   round_done    : one-cycle pulse at round completion
//   err_vec       : sticky per-channel mismatch/timeout flags
//   timeout_err   : sticky, some channel timed out
//   overrun       : sticky, tick arrived during a round
//
// Optional build macro CMP_SCHED_STATS_EN adds:
//   round_cnt     : completed rounds, 16-bit wrapping
//   miss_cnt      : overrun ticks, 8-bit saturating
// ---------------------------------------------------------------------------
module cmp_scheduler #(
    parameter int NCH     = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [NCH-1:0]   ch_en,
    input  logic             err_clr,
    output logic             cmp_start,
    output logic [SEL_W-1:0] cmp_sel,
    input  logic             cmp_done,
    input  logic             cmp_mismatch,
    output logic             busy,
    output logic             round_done,
    output logic [NCH-1:0]   err_vec,
    output logic             timeout_err,
    output logic             overrun
`ifdef CMP_SCHED_STATS_EN
    ,
    output logic [15:0]      round_cnt,
    output logic [7:0]       miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NCH-1:0]   pend_mask;
    logic [TO_W-1:0]  to_cnt;
    logic             wait_done_s;
    logic             wait_to_s;
    logic             overrun_ev_s;
    logic [NCH-1:0]   set_vec_s;

    // Index of the lowest set bit; highest index is scanned first so the
    // lowest one found is the last (and winning) assignment.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NCH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Handshake outcome decode; a done in the timeout cycle takes priority.
    always_comb begin
        wait_done_s  = (state == WAIT) && cmp_done;
        wait_to_s    = (state == WAIT) && !cmp_done && (to_cnt == TO_W'(TIMEOUT - 1));
        overrun_ev_s = tick && (state != IDLE);
        set_vec_s    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cmp_sel == SEL_W'(i)) begin
                set_vec_s[i] = (wait_done_s && cmp_mismatch) || wait_to_s;
            end else begin
                set_vec_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tick && (ch_en != '0)) begin
                    state_next = SELECT;
                end else begin
                    state_next = IDLE;
                end
            end
            SELECT: state_next = START;
            START:  state_next = WAIT;
            WAIT: begin
                if (wait_done_s || wait_to_s) begin
                    state_next = NEXT;
                end else begin
                    state_next = WAIT;
                end
            end
            NEXT: begin
                if (pend_mask != '0) begin
                    state_next = SELECT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered control outputs, derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmp_start  <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
        end else begin
            state      <= state_next;
            cmp_start  <= (state_next == START);
            busy       <= (state_next != IDLE);
            round_done <= (state == NEXT) && (state_next == IDLE);
        end
    end

    // Pending mask, channel select and per-channel timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mask <= '0;
            cmp_sel   <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && (ch_en != '0)) begin
                        pend_mask <= ch_en;
                    end else begin
                        pend_mask <= pend_mask;
                    end
                end
                SELECT: begin
                    cmp_sel   <= lowest_idx(pend_mask);
                    // m & (m-1) drops exactly the lowest set bit
                    pend_mask <= pend_mask & (pend_mask - NCH'(1));
                end
                START: to_cnt <= '0;
                WAIT: begin
                    if (!wait_done_s && !wait_to_s) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end else begin
                        to_cnt <= to_cnt;
                    end
                end
                default: begin
                    pend_mask <= pend_mask;
                end
            endcase
        end
    end

    // Sticky status; a set event in the clear cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_vec     <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_vec     <= (err_clr ? '0 : err_vec) | set_vec_s;
            timeout_err <= (timeout_err && !err_clr) || wait_to_s;
            overrun     <= (overrun && !err_clr) || overrun_ev_s;
        end
    end

`ifdef CMP_SCHED_STATS_EN
    // Round and missed-tick statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt <= 16'd0;
            miss_cnt  <= 8'd0;
        end else begin
            if (err_clr) begin
                round_cnt <= 16'd0;
            end else if ((state == NEXT) && (state_next == IDLE)) begin
                round_cnt <= round_cnt + 16'd1;
            end else begin
                round_cnt <= round_cnt;
            end
            if (err_clr) begin
                miss_cnt <= 8'd0;
            end else if (overrun_ev_s && (miss_cnt != 8'hFF)) begin
                miss_cnt <= miss_cnt + 8'd1;
            end else begin
                miss_cnt <= miss_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmp_scheduler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cmp_scheduler. A round-level reference model turns
// {enable mask, per-channel comparator latency, mismatch pattern} into the
// expected start/select/busy/round_done timeline and the resulting sticky
// flags, using the handshake timing rules directly.
// ---------------------------------------------------------------------------
module tb_cmp_scheduler;
    localparam int NCH     = 4;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;
    localparam int NEVER   = 999;
    localparam int MAXC    = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [NCH-1:0]   ch_en;
    logic             err_clr;
    logic             cmp_start;
    logic [SEL_W-1:0] cmp_sel;
    logic             cmp_done;
    logic             cmp_mismatch;
    logic             busy;
    logic             round_done;
    logic [NCH-1:0]   err_vec;
    logic             timeout_err;
    logic             overrun;
`ifdef CMP_SCHED_STATS_EN
    logic [15:0]      round_cnt;
    logic [7:0]       miss_cnt;
    int               m_rc;
    int               m_mc;
`endif

    cmp_scheduler #(.NCH(NCH), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .ch_en(ch_en), .err_clr(err_clr),
        .cmp_start(cmp_start), .cmp_sel(cmp_sel), .cmp_done(cmp_done),
        .cmp_mismatch(cmp_mismatch), .busy(busy), .round_done(round_done),
        .err_vec(err_vec), .timeout_err(timeout_err), .overrun(overrun)
`ifdef CMP_SCHED_STATS_EN
        , .round_cnt(round_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         lat [NCH];
    logic [3:0] mm;
    logic [3:0] m_err;
    logic       m_to;
    logic       m_ov;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] later_en;
        int         l0, l1, l2, l3;
        logic [3:0] mm;
        int         xtick;
        logic [3:0] exp_err;
        logic       exp_to;
        logic       exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef CMP_SCHED_STATS_EN
        check("round_cnt", 32'(round_cnt), 32'(m_rc));
        check("miss_cnt", 32'(miss_cnt), 32'(m_mc));
`endif
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick = 1'b0;
        step();
        err_clr = 1'b0;
        m_err = 4'b0000; m_to = 1'b0; m_ov = 1'b0;
`ifdef CMP_SCHED_STATS_EN
        m_rc = 0; m_mc = 0;
`endif
        check("clr_err_vec", 32'(err_vec), 32'(m_err));
        check("clr_timeout", 32'(timeout_err), 32'(m_to));
        check("clr_overrun", 32'(overrun), 32'(m_ov));
    endtask

    // Round model: first start 2 cycles after tick; a channel ends at
    // start+lat when lat<=TIMEOUT (done wins at the boundary), else at
    // start+TIMEOUT as a timeout; next start 3 cycles after the end;
    // round_done and busy-low 2 cycles after the last end.
    task automatic run_round(input logic [3:0] mask, input logic [3:0] later_en, input int xtick_in);
        bit         es   [MAXC];
        int         esel [MAXC];
        bit         dn   [MAXC];
        logic       dmm  [MAXC];
        int         cur, fin, last_end, rd_at, busy_hi, ncyc, xtick, c;
        for (int i = 0; i < MAXC; i++) begin
            es[i] = 1'b0; esel[i] = 0; dn[i] = 1'b0; dmm[i] = 1'b0;
        end
        cur = 2; last_end = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                es[cur] = 1'b1;
                esel[cur] = ch;
                if (lat[ch] != NEVER) begin
                    dn[cur + lat[ch]] = 1'b1;
                    dmm[cur + lat[ch]] = mm[ch];
                end
                if (lat[ch] <= TIMEOUT) begin
                    fin = cur + lat[ch];
                    if (mm[ch]) m_err[ch] = 1'b1;
                end else begin
                    fin = cur + TIMEOUT;
                    m_err[ch] = 1'b1;
                    m_to = 1'b1;
                end
                last_end = fin;
                cur = fin + 3;
            end
        end
        if (mask != 4'b0000) begin
            rd_at = last_end + 2; busy_hi = last_end + 1; ncyc = last_end + 4;
`ifdef CMP_SCHED_STATS_EN
            m_rc++;
`endif
        end else begin
            rd_at = -1; busy_hi = 0; ncyc = 6;
        end
        xtick = xtick_in;
        if (xtick == -2) xtick = (mask != 4'b0000) ? int'($urandom_range(1, busy_hi)) : -1;
        if (xtick >= 1 && xtick <= busy_hi) begin
            m_ov = 1'b1;
`ifdef CMP_SCHED_STATS_EN
            m_mc++;
`endif
        end
        for (int rel = 0; rel < ncyc; rel++) begin
            tick = (rel == 0) || (rel == xtick);
            ch_en = (rel == 0) ? mask : later_en;
            cmp_done = dn[rel];
            cmp_mismatch = dn[rel] ? dmm[rel] : 1'($urandom_range(0, 1));
            step();
            c = rel + 1;
            check("cmp_start", 32'(cmp_start), 32'(es[c]));
            if (es[c]) check("cmp_sel", 32'(cmp_sel), 32'(esel[c]));
            check("busy", 32'(busy), 32'(c >= 1 && c <= busy_hi));
            check("round_done", 32'(round_done), 32'(c == rd_at));
        end
        tick = 1'b0; cmp_done = 1'b0; cmp_mismatch = 1'b0;
        check("err_vec", 32'(err_vec), 32'(m_err));
        check("timeout_err", 32'(timeout_err), 32'(m_to));
        check("overrun", 32'(overrun), 32'(m_ov));
        check_stats();
    endtask

    initial begin
        vec_t tab [11];
        tab[0]  = '{4'b1011, 4'b1011, 3, 3, 3, 3, 4'b0000, -1, 4'b0000, 1'b0, 1'b0};
        tab[1]  = '{4'b1011, 4'b1011, 3, 3, 3, 3, 4'b0010, -1, 4'b0010, 1'b0, 1'b0};
        tab[2]  = '{4'b0100, 4'b0100, 3, 3, NEVER, 3, 4'b0000, -1, 4'b0100, 1'b1, 1'b0};
        tab[3]  = '{4'b0100, 4'b0100, 3, 3, 16, 3, 4'b0000, -1, 4'b0000, 1'b0, 1'b0};
        tab[4]  = '{4'b0100, 4'b0100, 3, 3, 16, 3, 4'b0100, -1, 4'b0100, 1'b0, 1'b0};
        tab[5]  = '{4'b0100, 4'b0100, 3, 3, 15, 3, 4'b0000, -1, 4'b0000, 1'b0, 1'b0};
        tab[6]  = '{4'b1011, 4'b1011, 3, 3, 3, 3, 4'b0000, 6, 4'b0000, 1'b0, 1'b1};
        tab[7]  = '{4'b0000, 4'b0000, 3, 3, 3, 3, 4'b1111, -1, 4'b0000, 1'b0, 1'b0};
        tab[8]  = '{4'b0011, 4'b1100, 2, 2, 2, 2, 4'b1100, -1, 4'b0000, 1'b0, 1'b0};
        tab[9]  = '{4'b1111, 4'b1111, 1, 17, NEVER, 1, 4'b1111, -1, 4'b1111, 1'b1, 1'b0};
        tab[10] = '{4'b1000, 4'b1000, 2, 2, 2, 1, 4'b0000, -1, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1; tick = 1'b0; ch_en = 4'b0000; err_clr = 1'b0;
        cmp_done = 1'b0; cmp_mismatch = 1'b0; mm = 4'b0000;
        m_err = 4'b0000; m_to = 1'b0; m_ov = 1'b0;
`ifdef CMP_SCHED_STATS_EN
        m_rc = 0; m_mc = 0;
`endif
        step(); step();
        check("rst_cmp_start", 32'(cmp_start), 32'd0);
        check("rst_cmp_sel", 32'(cmp_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_round_done", 32'(round_done), 32'd0);
        check("rst_err_vec", 32'(err_vec), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            clear_flags();
            lat[0] = tab[v].l0; lat[1] = tab[v].l1; lat[2] = tab[v].l2; lat[3] = tab[v].l3;
            mm = tab[v].mm;
            run_round(tab[v].mask, tab[v].later_en, tab[v].xtick);
            check("tab_err_vec", 32'(err_vec), 32'(tab[v].exp_err));
            check("tab_timeout", 32'(timeout_err), 32'(tab[v].exp_to));
            check("tab_overrun", 32'(overrun), 32'(tab[v].exp_ov));
            step();
        end

        // Reset during WAIT on channel 2, with overrun already flagged.
        clear_flags();
        ch_en = 4'b0100; tick = 1'b1; step();      // cycle 1: SELECT
        tick = 1'b0; step();                       // cycle 2: START
        check("seq_start", 32'(cmp_start), 32'd1);
        check("seq_sel", 32'(cmp_sel), 32'd2);
        step();                                    // cycle 3: WAIT
        tick = 1'b1; step();                       // cycle 4: overrun visible
        tick = 1'b0;
        check("seq_overrun", 32'(overrun), 32'd1);
        step();                                    // cycle 5: WAIT
        rst = 1'b1; step();
        rst = 1'b0;
        check("mid_rst_cmp_start", 32'(cmp_start), 32'd0);
        check("mid_rst_cmp_sel", 32'(cmp_sel), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_round_done", 32'(round_done), 32'd0);
        check("mid_rst_err_vec", 32'(err_vec), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        m_err = 4'b0000; m_to = 1'b0; m_ov = 1'b0;
`ifdef CMP_SCHED_STATS_EN
        m_rc = 0; m_mc = 0;
`endif
        step(); step();
        lat[0] = 2; lat[1] = 2; lat[2] = 2; lat[3] = 2; mm = 4'b0000;
        run_round(4'b0001, 4'b0001, -1);
        step();

        // Randomized rounds against the model; flags accumulate unless cleared.
        for (int r = 0; r < 40; r++) begin
            int pick;
            if ($urandom_range(0, 1) == 1) clear_flags();
            for (int ch = 0; ch < NCH; ch++) begin
                pick = int'($urandom_range(0, 11));
                if (pick <= 5)       lat[ch] = int'($urandom_range(1, 6));
                else if (pick == 6)  lat[ch] = 15;
                else if (pick == 7)  lat[ch] = 16;
                else if (pick == 8)  lat[ch] = 17;
                else if (pick == 9)  lat[ch] = 18;
                else if (pick == 10) lat[ch] = NEVER;
                else                 lat[ch] = int'($urandom_range(7, 14));
            end
            mm = 4'($urandom_range(0, 15));
            run_round(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1) ? -2 : -1);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
